// File: rtl/ub_read_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ub_read_sequencer_pkg
// Shared definitions for the unified-buffer read sequencer and the buffer
// itself: FSM state type, default geometry localparams, and helpers that
// derive address/data widths from the module parameters.
// ---------------------------------------------------------------------------
package ub_read_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  // Default geometry: 2 lanes, 4 banks of 8 rows each.
  localparam int SaLength  = 2;
  localparam int AddrWidth = 3 + $clog2(4);
  localparam int DataWidth = 8 * SaLength;

  function automatic int addr_width_f(input int addr_bits, input int banks);
    return addr_bits + $clog2(banks);
  endfunction

  function automatic int data_width_f(input int lanes);
    return 8 * lanes;
  endfunction

endpackage

// File: rtl/ub_read_sequencer_lane_skew.sv
// ---------------------------------------------------------------------------
// ub_read_sequencer_lane_skew
// Delays one 8-bit lane and its valid flag by DEPTH clock-enabled cycles.
// DEPTH = 0 is a combinational bypass with no registers.
//
// Ports
//   clk, async_rst, sync_rst, en : clock, resets (both active high), enable
//   in_data / in_valid           : lane byte and its valid
//   out_data / out_valid         : same, DEPTH cycles later
// ---------------------------------------------------------------------------
module ub_read_sequencer_lane_skew #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       async_rst,
  input  logic       sync_rst,
  input  logic       en,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, async_rst, sync_rst, en};
      assign out_data  = in_data;
      assign out_valid = in_valid;
    end else begin : g_shift
      logic [7:0]       data_q [DEPTH];
      logic [DEPTH-1:0] valid_q;

      always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
          for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
          valid_q <= '0;
        end else if (sync_rst) begin
          for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
          valid_q <= '0;
        end else if (en) begin
          data_q[0]  <= in_data;
          valid_q[0] <= in_valid;
          for (int s = 1; s < DEPTH; s++) begin
            data_q[s]  <= data_q[s-1];
            valid_q[s] <= valid_q[s-1];
          end
        end
      end

      assign out_data  = data_q[DEPTH-1];
      assign out_valid = valid_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/ub_read_sequencer.sv
// ---------------------------------------------------------------------------
// ub_read_sequencer
// Streams num_rows consecutive rows of the unified buffer, starting at
// base_addr, into the systolic array. Each row is split into SA_LENGTH
// byte lanes; lane i feeds array row i.
//
// Build option: define UB_RDSEQ_SKEW_EN to delay lane i by i extra cycles
// (diagonal skew). Without it all lanes of a row are presented together and
// no skew registers exist.
//
// Ports
//   clk        : rising-edge clock
//   async_rst  : asynchronous active-high reset
//   sync_rst   : synchronous active-high reset, wins over en
//   en         : clock enable, low freezes everything
//   start      : one-cycle request, honoured only when idle and done is low
//   base_addr  : first row to read
//   num_rows   : rows to stream, 0 .. 2^ADDR_W
//   rdaddr     : buffer read address (holds when not issuing)
//   rddata     : buffer data, valid one cycle after rdaddr
//   sa_data    : lane outputs, zero where the lane is not valid
//   sa_valid   : per-lane valid
//   busy       : job in progress
//   done       : one-cycle completion pulse
// ---------------------------------------------------------------------------
module ub_read_sequencer
  import ub_read_sequencer_pkg::*;
#(
  parameter  int SA_LENGTH  = 2,
  parameter  int ADDR_WIDTH = 3,
  parameter  int NO_BANKS   = 4,
  localparam int ADDR_W     = addr_width_f(ADDR_WIDTH, NO_BANKS),
  localparam int DATA_W     = data_width_f(SA_LENGTH)
) (
  input  logic                 clk,
  input  logic                 async_rst,
  input  logic                 sync_rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      num_rows,
  output logic [ADDR_W-1:0]    rdaddr,
  input  logic [DATA_W-1:0]    rddata,
  output logic [DATA_W-1:0]    sa_data,
  output logic [SA_LENGTH-1:0] sa_valid,
  output logic                 busy,
  output logic                 done
);

`ifdef UB_RDSEQ_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif

  // Cycles spent in DRAIN after the last address: covers the buffer read,
  // the lane skew of the last lane and the output register.
  localparam int                DRAIN_W   = (SA_LENGTH > 0) ? $clog2(SA_LENGTH + 1) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAT = DRAIN_W'((SKEW != 0) ? SA_LENGTH : 1);

  seq_state_t           state;
  logic [ADDR_W:0]      row_cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 issue_v;
  logic                 rd_v;

  logic [7:0]           lane_d [SA_LENGTH];
  logic [SA_LENGTH-1:0] lane_v;

  // Control FSM. issue_v marks cycles where rdaddr carries a real request;
  // rd_v is that flag aligned with the returning rddata.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state     <= IDLE;
      row_cnt   <= '0;
      drain_cnt <= '0;
      issue_v   <= 1'b0;
      rd_v      <= 1'b0;
      rdaddr    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (sync_rst) begin
      state     <= IDLE;
      row_cnt   <= '0;
      drain_cnt <= '0;
      issue_v   <= 1'b0;
      rd_v      <= 1'b0;
      rdaddr    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (en) begin
      done <= 1'b0;
      rd_v <= issue_v;
      case (state)
        IDLE: begin
          // A start seen while done is still high belongs to the old job.
          if (start && !done) begin
            if (num_rows == '0) begin
              done <= 1'b1;
            end else begin
              state   <= ISSUE;
              busy    <= 1'b1;
              rdaddr  <= base_addr;
              issue_v <= 1'b1;
              row_cnt <= num_rows - (ADDR_W + 1)'(1);
            end
          end
        end
        ISSUE: begin
          if (row_cnt == '0) begin
            state     <= DRAIN;
            issue_v   <= 1'b0;
            drain_cnt <= DRAIN_LAT;
          end else begin
            // Natural overflow gives the modulo-2^ADDR_W wrap.
            rdaddr  <= rdaddr + ADDR_W'(1);
            row_cnt <= row_cnt - (ADDR_W + 1)'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-lane skew: lane i sees i extra cycles of delay when skew is built in,
  // otherwise every lane is a plain bypass.
  generate
    for (genvar i = 0; i < SA_LENGTH; i++) begin : g_lane
      ub_read_sequencer_lane_skew #(
        .DEPTH(i * SKEW)
      ) u_skew (
        .clk      (clk),
        .async_rst(async_rst),
        .sync_rst (sync_rst),
        .en       (en),
        .in_data  (rddata[8*i +: 8]),
        .in_valid (rd_v),
        .out_data (lane_d[i]),
        .out_valid(lane_v[i])
      );
    end
  endgenerate

  // Output register; invalid lanes are forced to zero.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      sa_data  <= '0;
      sa_valid <= '0;
    end else if (sync_rst) begin
      sa_data  <= '0;
      sa_valid <= '0;
    end else if (en) begin
      for (int i = 0; i < SA_LENGTH; i++) begin
        sa_valid[i]       <= lane_v[i];
        sa_data[8*i +: 8] <= lane_v[i] ? lane_d[i] : 8'h00;
      end
    end
  end

endmodule
